// File: rtl/gate_bank_filt.sv
// Bank of run-time selectable logic gates with synchronised pin inputs and
// per-channel glitch filtering on the registered outputs.
module gate_bank_filt #(
  parameter int CHANNELS    = 3,
  parameter int INPUTS      = 3,
  parameter int FILT_CYCLES = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic [2:0]                   MODE,
  input  logic [CHANNELS*INPUTS-1:0]   A,
  output logic [CHANNELS-1:0]          Y,
  output logic [CHANNELS-1:0]          CHG
);

  localparam int              CW       = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_CYCLES - 1);

  localparam logic [2:0] MODE_NAND = 3'b001;
  localparam logic [2:0] MODE_OR   = 3'b010;
  localparam logic [2:0] MODE_NOR  = 3'b011;
  localparam logic [2:0] MODE_XOR  = 3'b100;
  localparam logic [2:0] MODE_XNOR = 3'b101;

  logic [CHANNELS*INPUTS-1:0] aMeta_q, aSync_q;
  logic [2:0]                 modeMeta_q, modeSync_q;
  logic [CHANNELS-1:0]        raw;
  logic [CHANNELS-1:0]        y_q, y_d;
  logic [CHANNELS-1:0]        chg_q, chg_d;
  logic [CW-1:0]              cnt_q [CHANNELS];
  logic [CW-1:0]              cnt_d [CHANNELS];

  // Two-flop synchronisers for every asynchronous pin.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      aMeta_q    <= '0;
      aSync_q    <= '0;
      modeMeta_q <= '0;
      modeSync_q <= '0;
    end else begin
      aMeta_q    <= A;
      aSync_q    <= aMeta_q;
      modeMeta_q <= MODE;
      modeSync_q <= modeMeta_q;
    end
  end

  always_comb begin
    logic [INPUTS-1:0] bits;
    bits = '0;
    raw  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bits = aSync_q[c*INPUTS +: INPUTS];
      case (modeSync_q)
        MODE_NAND: raw[c] = ~(&bits);
        MODE_OR:   raw[c] = |bits;
        MODE_NOR:  raw[c] = ~(|bits);
        MODE_XOR:  raw[c] = ^bits;
        MODE_XNOR: raw[c] = ~(^bits);
        default:   raw[c] = &bits;
      endcase
    end
  end

  // Y flips only on the FILT_CYCLES-th consecutive enabled mismatch; any
  // matching edge restarts the count.
  always_comb begin
    y_d   = y_q;
    chg_d = '0;
    cnt_d = cnt_q;
    if (EN) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (raw[c] == y_q[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CNT_LAST) begin
          y_d[c]   = raw[c];
          chg_d[c] = 1'b1;
          cnt_d[c] = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      y_q   <= '0;
      chg_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      y_q   <= y_d;
      chg_q <= chg_d;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign Y   = y_q;
  assign CHG = chg_q;

endmodule

// File: tb/tb_gate_bank_filt.sv
// Bench for gate_bank_filt: a default 3x3 filter-4 instance and an 8x2
// filter-1 instance, checked against a behavioural model plus directed cases.
module tb_gate_bank_filt;

  localparam int CH_A = 3, IN_A = 3, F_A = 4;
  localparam int CH_B = 8, IN_B = 2, F_B = 1;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [2:0]           mode;
  logic [CH_A*IN_A-1:0] aA;
  logic [CH_B*IN_B-1:0] aB;
  logic [CH_A-1:0]      yA, chgA;
  logic [CH_B-1:0]      yB, chgB;

  int checks = 0;
  int errors = 0;

  gate_bank_filt #(.CHANNELS(CH_A), .INPUTS(IN_A), .FILT_CYCLES(F_A)) dutA (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .A(aA), .Y(yA), .CHG(chgA)
  );

  gate_bank_filt #(.CHANNELS(CH_B), .INPUTS(IN_B), .FILT_CYCLES(F_B)) dutB (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .A(aB), .Y(yB), .CHG(chgB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Gate function from the count of ones among the channel's n inputs.
  function automatic logic gateRef(input logic [2:0] m, input logic [7:0] bits, input int n);
    int ones;
    ones = $countones(bits);
    case (m)
      3'd1:    return ones != n;
      3'd2:    return ones > 0;
      3'd3:    return ones == 0;
      3'd4:    return (ones % 2) == 1;
      3'd5:    return (ones % 2) == 0;
      default: return ones == n;
    endcase
  endfunction

  // Reference model: pins delayed two samples, then a mismatch run length.
  logic [CH_A*IN_A-1:0] pipeA [2];
  logic [CH_B*IN_B-1:0] pipeB [2];
  logic [2:0]           pipeM [2];
  int                   runA [CH_A];
  int                   runB [CH_B];
  logic [CH_A-1:0]      expYA, expChgA;
  logic [CH_B-1:0]      expYB, expChgB;
  logic                 r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeA = '{default: '0};
      pipeB = '{default: '0};
      pipeM = '{default: '0};
      runA  = '{default: 0};
      runB  = '{default: 0};
      expYA = '0; expChgA = '0;
      expYB = '0; expChgB = '0;
    end else begin
      for (int c = 0; c < CH_A; c++) begin
        r = gateRef(pipeM[1], 8'(pipeA[1][c*IN_A +: IN_A]), IN_A);
        expChgA[c] = 1'b0;
        if (en) begin
          if (r == expYA[c]) runA[c] = 0;
          else begin
            runA[c]++;
            if (runA[c] >= F_A) begin
              expYA[c] = r; expChgA[c] = 1'b1; runA[c] = 0;
            end
          end
        end
      end
      for (int c = 0; c < CH_B; c++) begin
        r = gateRef(pipeM[1], 8'(pipeB[1][c*IN_B +: IN_B]), IN_B);
        expChgB[c] = 1'b0;
        if (en) begin
          if (r == expYB[c]) runB[c] = 0;
          else begin
            runB[c]++;
            if (runB[c] >= F_B) begin
              expYB[c] = r; expChgB[c] = 1'b1; runB[c] = 0;
            end
          end
        end
      end
      pipeA[1] = pipeA[0]; pipeA[0] = aA;
      pipeB[1] = pipeB[0]; pipeB[0] = aB;
      pipeM[1] = pipeM[0]; pipeM[0] = mode;
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 3'b000; aA = '0; aB = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({yA, chgA, yB, chgB} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got yA=%b chgA=%b yB=%b chgB=%b, expected all zero", yA, chgA, yB, chgB);
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({yA, chgA, yB, chgB} !== '0) begin
        errors++;
        $display("[TB] FAIL idle_after_reset: cycle %0d got yA=%b chgA=%b yB=%b chgB=%b, expected zero", k, yA, chgA, yB, chgB);
      end
    end
  endtask

  task automatic test_basic_and();
    logic expY0, expC0;
    aA[2:0] = 3'b111;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      expY0 = (k >= 6);
      expC0 = (k == 6);
      checks++;
      if (yA !== {2'b00, expY0} || chgA !== {2'b00, expC0}) begin
        errors++;
        $display("[TB] FAIL and_latency: edge %0d got Y=%b CHG=%b, expected Y=%b CHG=%b", k, yA, chgA, {2'b00, expY0}, {2'b00, expC0});
      end
    end
  endtask

  task automatic test_glitch();
    logic expY0, expC0;
    aA[0] = 1'b0;
    repeat (3) @(negedge clk);
    aA[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (yA[0] !== 1'b1 || chgA[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL glitch_reject: cycle %0d got Y0=%b CHG0=%b, expected 1/0", k, yA[0], chgA[0]);
      end
    end
    aA[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      expY0 = (k < 6);
      expC0 = (k == 6);
      checks++;
      if (yA[0] !== expY0 || chgA[0] !== expC0) begin
        errors++;
        $display("[TB] FAIL glitch_pass: edge %0d got Y0=%b CHG0=%b, expected %b/%b", k, yA[0], chgA[0], expY0, expC0);
      end
    end
    aA[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({yA, chgA} !== {expYA, expChgA}) begin
        errors++;
        $display("[TB] FAIL glitch_recover: got Y=%b CHG=%b, expected Y=%b CHG=%b", yA, chgA, expYA, expChgA);
      end
    end
  endtask

  task automatic test_modes();
    logic [7:0] tbl;
    logic       prev;
    tbl = 8'b0010_0110;
    prev = 1'b0;
    aA[5:3] = 3'b011;
    for (int m = 0; m < 8; m++) begin
      mode = 3'(m);
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 5) begin
          checks++;
          if (yA[1] !== prev) begin
            errors++;
            $display("[TB] FAIL mode_early: mode %0d got Y1=%b, expected %b", m, yA[1], prev);
          end
        end
        if (k == 6) begin
          checks++;
          if (yA[1] !== tbl[m] || chgA[1] !== (tbl[m] != prev)) begin
            errors++;
            $display("[TB] FAIL mode_value: mode %0d got Y1=%b CHG1=%b, expected %b/%b", m, yA[1], chgA[1], tbl[m], tbl[m] != prev);
          end
        end
        checks++;
        if ({yA, chgA, yB, chgB} !== {expYA, expChgA, expYB, expChgB}) begin
          errors++;
          $display("[TB] FAIL mode_model: mode %0d got %b %b %b %b, expected %b %b %b %b", m, yA, chgA, yB, chgB, expYA, expChgA, expYB, expChgB);
        end
      end
      prev = tbl[m];
    end
    mode = 3'b000;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_en_hold();
    aA[8:6] = 3'b111;
    repeat (4) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (yA[2] !== 1'b0 || chgA !== '0 || chgB !== '0) begin
        errors++;
        $display("[TB] FAIL en_hold: cycle %0d got Y2=%b chgA=%b chgB=%b, expected 0/000/00000000", k, yA[2], chgA, chgB);
      end
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (yA[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_resume_early: got Y2=%b, expected 0", yA[2]);
    end
    @(negedge clk);
    checks++;
    if (yA[2] !== 1'b1 || chgA[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL en_resume: got Y2=%b CHG2=%b, expected 1/1", yA[2], chgA[2]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_count();
    aA[8:6] = 3'b000;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    aA = '0;
    aB = '0;
    #1;
    checks++;
    if ({yA, chgA, yB, chgB} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got yA=%b chgA=%b yB=%b chgB=%b, expected zero", yA, chgA, yB, chgB);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({yA, chgA, yB, chgB} !== '0) begin
        errors++;
        $display("[TB] FAIL no_spurious: cycle %0d got yA=%b chgA=%b yB=%b chgB=%b, expected zero", k, yA, chgA, yB, chgB);
      end
    end
  endtask

  task automatic test_filt1_channels();
    logic [7:0] oh;
    mode = 3'b010;
    aB = '0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < CH_B; c++) begin
      oh = 8'(1 << c);
      aB = 16'(1 << (c * IN_B));
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        checks++;
        if (yB !== ((k == 3) ? oh : 8'h00) || chgB !== ((k == 3) ? oh : 8'h00)) begin
          errors++;
          $display("[TB] FAIL filt1_rise: ch %0d edge %0d got Y=%b CHG=%b", c, k, yB, chgB);
        end
      end
      aB = '0;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        checks++;
        if (yB !== ((k == 3) ? 8'h00 : oh) || chgB !== ((k == 3) ? oh : 8'h00)) begin
          errors++;
          $display("[TB] FAIL filt1_fall: ch %0d edge %0d got Y=%b CHG=%b", c, k, yB, chgB);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [CH_A-1:0] prevChgA;
    prevChgA = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) aA = 9'($urandom);
      aB = 16'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 3'($urandom);
      en = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      checks++;
      if ({yA, chgA, yB, chgB} !== {expYA, expChgA, expYB, expChgB}) begin
        errors++;
        $display("[TB] FAIL random_model: cycle %0d got %b %b %b %b, expected %b %b %b %b", k, yA, chgA, yB, chgB, expYA, expChgA, expYB, expChgB);
      end
      checks++;
      if ((chgA & prevChgA) !== '0) begin
        errors++;
        $display("[TB] FAIL chg_double: cycle %0d got CHG=%b after %b, expected no repeated pulse", k, chgA, prevChgA);
      end
      prevChgA = chgA;
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_and();
    test_glitch();
    test_modes();
    test_en_hold();
    test_reset_mid_count();
    test_filt1_channels();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
